// File: rtl/cpu_sequencer.sv
// Phase sequencer for the RISC CPU core: steps the 8-phase instruction cycle and
// decodes opcode/zero into the datapath strobes. Outputs are pure decodes of state.
module cpu_sequencer #(
    parameter int OPC_WIDTH   = 3,
    parameter int PHASE_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OPC_WIDTH-1:0]   opcode,
    input  logic                   zero,
    output logic                   sel,
    output logic                   rd,
    output logic                   wr,
    output logic                   ld_ir,
    output logic                   inc_pc,
    output logic                   ld_pc,
    output logic                   ld_ac,
    output logic                   data_e,
    output logic                   halt,
    output logic [PHASE_WIDTH-1:0] phase
);

    typedef enum logic [PHASE_WIDTH-1:0] {
        INST_ADDR  = PHASE_WIDTH'(0),
        INST_FETCH = PHASE_WIDTH'(1),
        INST_LOAD  = PHASE_WIDTH'(2),
        IDLE       = PHASE_WIDTH'(3),
        OP_ADDR    = PHASE_WIDTH'(4),
        OP_FETCH   = PHASE_WIDTH'(5),
        ALU_OP     = PHASE_WIDTH'(6),
        STORE      = PHASE_WIDTH'(7)
    } phase_t;

    localparam logic [OPC_WIDTH-1:0] OP_HLT = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] OP_SKZ = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OP_ADD = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] OP_AND = OPC_WIDTH'(3);
    localparam logic [OPC_WIDTH-1:0] OP_XOR = OPC_WIDTH'(4);
    localparam logic [OPC_WIDTH-1:0] OP_LDA = OPC_WIDTH'(5);
    localparam logic [OPC_WIDTH-1:0] OP_STO = OPC_WIDTH'(6);
    localparam logic [OPC_WIDTH-1:0] OP_JMP = OPC_WIDTH'(7);

    phase_t phase_q;
    logic   halted_q;
    logic   alu_op;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            // HLT freezes the counter where it is; the phase output is forced to 0 instead.
            if (phase_q == OP_ADDR && opcode == OP_HLT) begin
                halted_q <= 1'b1;
            end else begin
                phase_q <= phase_t'(phase_q + 1'b1);
            end
        end
    end

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    // Opcode is only consulted in phases 4-7 so an IR being reloaded cannot leak through.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

    assign phase = halted_q ? '0 : phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a driver pushes expected output vectors from a
// phase-level reference model, a negedge monitor pops and compares them.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'd2;
    logic       zero = 1'b0;
    logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [2:0] phase;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // {phase[2:0], sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}
    logic [11:0] exp_q[$];

    int m_phase  = 0;
    bit m_halted = 0;
    bit m_valid  = 0;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e), .halt(halt), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_out(int ph, bit hl, logic [2:0] op, bit z);
        bit alu;
        logic [2:0] p3;
        if (hl) return 12'b000_0000_0000_1;
        alu = (op >= 3'd2) && (op <= 3'd5);
        p3  = ph[2:0];
        return {p3,
                ph < 4,                                   // sel
                (ph >= 1 && ph <= 3) || (ph >= 5 && alu), // rd
                ph == 7 && op == 3'd6,                    // wr
                ph == 2 || ph == 3,                       // ld_ir
                ph == 4 || (ph == 6 && op == 3'd1 && z),  // inc_pc
                op == 3'd7 && ph >= 6,                    // ld_pc
                ph == 7 && alu,                           // ld_ac
                op == 3'd6 && ph >= 6,                    // data_e
                ph == 4 && op == 3'd0};                   // halt
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model state advances as the DUT will at the next edge.
    task automatic cycle(input logic r, input logic [2:0] op, input logic z);
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
        zero   = z;
        if (m_valid) exp_q.push_back(model_out(m_phase, m_halted, op, z));
        if (!r) begin
            m_phase  = 0;
            m_halted = 0;
            m_valid  = 1;
        end else if (!m_halted) begin
            if (m_phase == 4 && op == 3'd0) m_halted = 1;
            else m_phase = (m_phase + 1) % 8;
        end
    endtask

    // One instruction starting at phase 0; rst_ph >= 0 pulls reset in that phase.
    task automatic run_instr(input logic [2:0] op, input logic z, input int rst_ph);
        logic [2:0] o;
        logic       zz;
        for (int p = 0; p < 8; p++) begin
            o  = (p < 4) ? 3'($urandom) : op;
            zz = (p == 6) ? z : 1'($urandom);
            cycle((p == rst_ph) ? 1'b0 : 1'b1, o, zz);
            if (p == rst_ph) break;
        end
    endtask

    task automatic hold_and_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 3'($urandom), 1'($urandom));
        cycle(1'b0, 3'($urandom), 1'($urandom));
    endtask

    initial begin : monitor
        logic [11:0] e;
        logic [11:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {phase, sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};
                check("outputs", a, e);
                check("rd_wr_exclusive", {11'd0, rd & wr}, 12'd0);
                check("ldpc_incpc_exclusive", {11'd0, ld_pc & inc_pc}, 12'd0);
                check("ldir_implies_sel", {11'd0, ld_ir & ~sel}, 12'd0);
            end
        end
    end

    initial begin : driver
        int op;
        int rph;
        cycle(1'b0, 3'd2, 1'b0);
        cycle(1'b0, 3'd2, 1'b0);
        run_instr(3'd2, 1'b0, -1);  // ADD
        run_instr(3'd2, 1'b1, -1);
        run_instr(3'd6, 1'b0, -1);  // STO
        run_instr(3'd1, 1'b1, -1);  // SKZ taken
        run_instr(3'd1, 1'b0, -1);  // SKZ not taken
        run_instr(3'd7, 1'b1, -1);  // JMP
        run_instr(3'd7, 1'b0, -1);
        run_instr(3'd0, 1'b0, -1);  // HLT
        hold_and_reset(20);
        run_instr(3'd2, 1'b0, -1);
        run_instr(3'd2, 1'b0, 5);   // reset mid-ADD at phase 5
        run_instr(3'd2, 1'b0, -1);
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 7);
            if (op == 0 && $urandom_range(0, 3) != 0) op = 2;
            rph = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : -1;
            run_instr(3'(op), 1'($urandom), rph);
            if (m_halted) hold_and_reset($urandom_range(1, 5));
        end
        repeat (2) @(posedge clk);
        check("queue_drained", 12'(exp_q.size()), 12'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Central phase-sequencing controller of the RISC CPU core.
- Steps an 8-phase instruction cycle: instruction address, fetch, load, idle, operand address, operand fetch, ALU op, store.
- Decodes the 3-bit opcode from the instruction register and the accumulator zero flag.
- Drives every datapath strobe: address mux select, memory read/write, IR load, PC increment/load, accumulator load, data bus enable, halt.

Parameters:
- OPC_WIDTH, `DATA_WIDTH-`ADDR_WIDTH (3): opcode width. Encodings are fixed: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- PHASE_WIDTH, 3: width of the phase counter and the debug phase output.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: reset. Synchronous, active-low: sampled only at the rising edge of clk, and rst=0 resets.
- opcode, input, OPC_WIDTH: current opcode from the instruction register.
- zero, input, 1: accumulator-is-zero flag.
- sel, output, 1: address mux select. 1=PC, 0=IR operand.
- rd, output, 1: memory read enable.
- wr, output, 1: memory write strobe.
- ld_ir, output, 1: instruction register load.
- inc_pc, output, 1: program counter increment.
- ld_pc, output, 1: program counter load (jump).
- ld_ac, output, 1: accumulator load.
- data_e, output, 1: accumulator drives data bus.
- halt, output, 1: CPU halted indication.
- phase, output, PHASE_WIDTH: current phase, 0..7. Reads 0 while halted.

Behaviour:
- State:
  - 3-bit phase counter, 0..7, wraps 7->0.
  - Sticky halted flag.
  - All outputs are combinational decodes of (phase, halted, opcode, zero); no output registers.
- Reset: rst=0 at a clk edge sets phase=0 and halted=0. This applies mid-instruction and while halted.
  - In the cycle after reset: sel=1, every other strobe=0, halt=0, phase=0.
- Normal operation: phase advances by 1 every clock.
- Helper terms: ALUOP = opcode in {ADD, AND, XOR, LDA}; HLT, SKZ, JMP, STO are the respective opcodes.
- Per-phase outputs (any strobe not listed is 0):
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1, halt=HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP, inc_pc=SKZ&zero, ld_pc=JMP, data_e=STO.
  - 7 STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- Opcode timing: opcode is ignored in phases 0-3, because the IR is being reloaded. It must be stable from phase 4 through phase 7.
- Halt:
  - In phase 4 with opcode=HLT, the next edge sets halted=1 and freezes the phase counter.
  - While halted: halt=1, phase output reads 0, all other strobes 0. This state holds until rst=0.
  - inc_pc=1 in the HLT phase 4 cycle is intentional: the PC points past the HLT.
- SKZ:
  - zero=1: inc_pc in phase 6, so the PC advances twice in the instruction (skip).
  - zero=0: a single increment only.
- JMP: ld_pc is asserted in both phases 6 and 7. The PC load is idempotent.
- STO: data_e is asserted in phases 6-7 and wr only in phase 7, giving one cycle of data setup before the write.
- Invariants:
  - wr and rd are never both 1.
  - ld_pc and inc_pc are never both 1.
  - ld_ir=1 only when sel=1.
- X on opcode during phases 0-3 must not propagate to any output.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release. Phase must read 0,1,2,...,7,0. sel=1 in phases 0-3 and 0 in phases 4-7. halt=0 throughout (opcode=ADD).
- ADD cycle (opcode=2): rd=1 in phases 1,2,3,5,6,7; ld_ir=1 in phases 2,3; inc_pc=1 in phase 4 only; ld_ac=1 in phase 7 only; wr=0 and data_e=0 throughout.
- STO (opcode=6): data_e=1 in phases 6,7; wr=1 in phase 7 only; rd=0 in phases 5-7; ld_ac=0.
- SKZ (opcode=1), zero=1 then zero=0:
  - zero=1: inc_pc pulses in phases 4 and 6 (2 pulses).
  - zero=0: phase 4 only (1 pulse).
- JMP (opcode=7): ld_pc=1 in phases 6,7; inc_pc=1 only in phase 4; ld_pc and inc_pc never both 1 across a 16-cycle run.
- HLT and reset recovery: opcode=0 at phase 4. The next edge gives halt=1, phase=0, all other strobes 0. This must hold for 20 cycles. Then rst=0 for 1 cycle mid-halt gives halt=0, phase=0, and normal sequencing resumes. Separately, assert rst=0 at phase 5 of an ADD: the next cycle shows phase=0 and ld_ac never pulses for that instruction.
